// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART transmit path: parity mode constants,
// transmitter state encoding and the parity helper used when a byte is
// accepted.
// ---------------------------------------------------------------------------
package uart_pkg;

   localparam int PAR_NONE = 0;
   localparam int PAR_ODD  = 1;
   localparam int PAR_EVEN = 2;

   // Widest legal data field; narrower words are zero-extended into it,
   // which leaves their XOR unchanged.
   localparam int MAX_DATA_BITS = 9;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_ARM    = 3'd1,
      ST_START  = 3'd2,
      ST_DATA   = 3'd3,
      ST_PARITY = 3'd4,
      ST_STOP   = 3'd5
   } tx_state_e;

   // Even parity bit is the XOR of the data; odd parity is its inverse.
   function automatic logic parity_bit(input logic [MAX_DATA_BITS-1:0] data,
                                       input int                       parity);
      logic x;
      x = ^data;
      return (parity == PAR_ODD) ? ~x : x;
   endfunction

endpackage

// File: rtl/uart_tick_edge.sv
// ---------------------------------------------------------------------------
// uart_tick_edge
// Turns the baud divider's square-wave output into a one-clk baud_tick
// pulse: two-flop synchroniser followed by a rising-edge detect. Sits beside
// uart_tx_frame at the integration level.
//
// Ports:
//   clk        system clock
//   rst        synchronous active-high reset
//   baud_sq    square wave from the baud divider (may be asynchronous)
//   baud_tick  one-cycle pulse per rising edge of baud_sq (registered)
// ---------------------------------------------------------------------------
module uart_tick_edge (
   input  logic clk,
   input  logic rst,
   input  logic baud_sq,
   output logic baud_tick
);

   logic sync1_q, sync1_d;
   logic sync2_q, sync2_d;
   logic prev_q,  prev_d;
   logic tick_q,  tick_d;

   always_comb begin
      sync1_d = baud_sq;
      sync2_d = sync1_q;
      prev_d  = sync2_q;
      tick_d  = sync2_q & ~prev_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         prev_q  <= 1'b0;
         tick_q  <= 1'b0;
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
         prev_q  <= prev_d;
         tick_q  <= tick_d;
      end
   end

   assign baud_tick = tick_q;

endmodule

// File: rtl/uart_tx_frame.sv
// ---------------------------------------------------------------------------
// uart_tx_frame
// Serial UART transmitter. Accepts a word over valid/ready while idle and
// shifts it out LSB-first as start / data / optional parity / stop bits, one
// bit per baud_tick period. The serial line is registered, so each line edge
// appears one clk after the tick that causes it.
//
// Ports:
//   clk         system clock
//   rst         synchronous active-high reset
//   baud_tick   one-clk enable per bit period
//   tx_data     word to send, sampled on accept
//   tx_valid    tx_data valid
//   tx_ready    high only while idle; accept = tx_valid & tx_ready
//   tx          serial line, idle high
//   busy        high whenever not idle
//   frame_done  one-clk pulse when the last stop bit completes
// ---------------------------------------------------------------------------
module uart_tx_frame
   import uart_pkg::*;
#(
   parameter int DATA_BITS = 8,
   parameter int PARITY    = PAR_NONE,
   parameter int STOP_BITS = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 baud_tick,
   input  logic [DATA_BITS-1:0] tx_data,
   input  logic                 tx_valid,
   output logic                 tx_ready,
   output logic                 tx,
   output logic                 busy,
   output logic                 frame_done
);

   if (DATA_BITS < 5 || DATA_BITS > MAX_DATA_BITS) begin : g_bad_data_bits
      $error("uart_tx_frame: DATA_BITS must be 5..9");
   end
   if (PARITY < PAR_NONE || PARITY > PAR_EVEN) begin : g_bad_parity
      $error("uart_tx_frame: PARITY must be 0, 1 or 2");
   end
   if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
      $error("uart_tx_frame: STOP_BITS must be 1 or 2");
   end

   localparam logic [3:0] LAST_BIT  = 4'(DATA_BITS - 1);
   localparam logic       LAST_STOP = 1'(STOP_BITS - 1);

   tx_state_e            state_q, state_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic [3:0]           bit_cnt_q, bit_cnt_d;
   logic                 stop_cnt_q, stop_cnt_d;
   logic                 par_q, par_d;
   logic                 tx_q, tx_d;
   logic                 frame_done_q, frame_done_d;

   always_comb begin
      state_d      = state_q;
      shift_d      = shift_q;
      bit_cnt_d    = bit_cnt_q;
      stop_cnt_d   = stop_cnt_q;
      par_d        = par_q;
      tx_d         = tx_q;
      frame_done_d = 1'b0;

      case (state_q)
         ST_IDLE: begin
            tx_d = 1'b1;
            if (tx_valid) begin
               shift_d = tx_data;
               par_d   = parity_bit(MAX_DATA_BITS'(tx_data), PARITY);
               state_d = ST_ARM;
            end
         end

         // Entered on the accept edge, so a tick coincident with the accept
         // is never seen here; the start bit waits for the next one.
         ST_ARM: begin
            if (baud_tick) begin
               tx_d    = 1'b0;
               state_d = ST_START;
            end
         end

         ST_START: begin
            if (baud_tick) begin
               tx_d      = shift_q[0];
               bit_cnt_d = 4'd0;
               state_d   = ST_DATA;
            end
         end

         ST_DATA: begin
            if (baud_tick) begin
               shift_d = shift_q >> 1;
               if (bit_cnt_q < LAST_BIT) begin
                  tx_d      = shift_d[0];
                  bit_cnt_d = bit_cnt_q + 4'd1;
               end else if (PARITY != PAR_NONE) begin
                  tx_d    = par_q;
                  state_d = ST_PARITY;
               end else begin
                  tx_d       = 1'b1;
                  stop_cnt_d = 1'b0;
                  state_d    = ST_STOP;
               end
            end
         end

         ST_PARITY: begin
            if (baud_tick) begin
               tx_d       = 1'b1;
               stop_cnt_d = 1'b0;
               state_d    = ST_STOP;
            end
         end

         // Line is already high; each tick closes one stop bit.
         ST_STOP: begin
            if (baud_tick) begin
               if (stop_cnt_q == LAST_STOP) begin
                  frame_done_d = 1'b1;
                  state_d      = ST_IDLE;
               end else begin
                  stop_cnt_d = stop_cnt_q + 1'b1;
               end
            end
         end

         default: begin
            tx_d    = 1'b1;
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         shift_q      <= '0;
         bit_cnt_q    <= 4'd0;
         stop_cnt_q   <= 1'b0;
         par_q        <= 1'b0;
         tx_q         <= 1'b1;
         frame_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         shift_q      <= shift_d;
         bit_cnt_q    <= bit_cnt_d;
         stop_cnt_q   <= stop_cnt_d;
         par_q        <= par_d;
         tx_q         <= tx_d;
         frame_done_q <= frame_done_d;
      end
   end

   assign tx         = tx_q;
   assign tx_ready   = (state_q == ST_IDLE);
   assign busy       = (state_q != ST_IDLE);
   assign frame_done = frame_done_q;

endmodule

// File: doc/uart_tx_frame.md
Name: uart_tx_frame

Overview:
Serial UART transmitter, directly downstream of the baud-rate divider stage. Accepts parallel bytes over a valid/ready handshake and shifts them out LSB-first as start / data / optional parity / stop bits. Each bit period equals the interval between successive baud_tick pulses. Fully synchronous to clk; baud_tick is a one-clk-wide enable, never used as a clock.

Parameters:
DATA_BITS, 8, data bits per frame, legal 5..9
PARITY, 0, 0 = none, 1 = odd, 2 = even
STOP_BITS, 1, number of stop bits, legal 1 or 2

Ports:
clk  in  1  system clock
rst  in  1  reset, synchronous, active-high
baud_tick  in  1  one-cycle pulse per bit period, from the divider/edge stage
tx_data  in  DATA_BITS  byte to send, sampled on accept
tx_valid  in  1  tx_data valid
tx_ready  out  1  high only in IDLE; accept = tx_valid & tx_ready on a rising clk edge
tx  out  1  serial line, registered, idle high
busy  out  1  high in every state except IDLE
frame_done  out  1  one-cycle pulse when the last stop bit completes

Behaviour:
- Reset values: tx=1, tx_ready=1, busy=0, frame_done=0, state=IDLE, shift register and counters = 0.
- Reset mid-frame: on the cycle after rst, tx=1 and state=IDLE. The captured byte is discarded and frame_done does not pulse.
- States: IDLE, ARM, START, DATA, PARITY, STOP.
- IDLE: tx=1. On accept, latch tx_data into the shift register, compute the parity bit from the latched data, go to ARM. tx_data and tx_valid are ignored outside IDLE.
- ARM: wait for baud_tick.
  - A baud_tick in the same cycle as the accept is not seen by ARM.
  - On the first tick in ARM: tx<=0, go to START.
- START: on tick, tx<=shift[0], bit_cnt<=0, go to DATA.
- DATA: on each tick, shift right.
  - If bit_cnt < DATA_BITS-1: tx<=next bit, bit_cnt++.
  - Otherwise: if PARITY != 0, tx<=parity and go to PARITY; else tx<=1 and go to STOP.
- PARITY: on tick, tx<=1, go to STOP.
- STOP: stop_cnt counts ticks.
  - On the STOP_BITS-th tick: go to IDLE, frame_done=1 for that cycle, tx stays 1.
- Between ticks, all state and tx hold.
- Bit timing: every bit of the frame lasts exactly one tick period. The tx edge is one clk after the tick (registered).
- Parity is computed from the latched data only:
  - even: XOR of all data bits
  - odd: inverted XOR of all data bits
- Back-to-back frames: the earliest accept is the cycle after frame_done. The start bit then begins on the next tick, so the idle gap is at least one tick period. Minimum frame period is 1 + DATA_BITS + (PARITY != 0) + STOP_BITS + 1 tick periods.
- baud_tick asserted on consecutive clk cycles: each cycle counts as a tick; no filtering.
- Illegal parameters (PARITY > 2, STOP_BITS outside 1..2, DATA_BITS outside 5..9) are rejected at elaboration.

Decomposition:
- Shared package uart_pkg:
  - parity constants PAR_NONE=0, PAR_ODD=1, PAR_EVEN=2
  - state encoding for IDLE..STOP
  - the parity function
- One natural sub-module: uart_tick_edge.
  - Converts the divider's square-wave baud output into the one-cycle baud_tick pulse.
  - Two-flop synchroniser plus rising-edge detect.
  - Same clk and synchronous active-high rst.
  - Instantiated beside uart_tx_frame at the integration level, not inside it.

Test Plan:
- Defaults, baud_tick every 5 clks, send 0x55 -> after the first post-accept tick, tx = 0,1,0,1,0,1,0,1,0,1, each held 5 clks. frame_done pulses once. busy drops with it.
- PARITY=2, send 0xA5 -> data bits 1,0,1,0,0,1,0,1, parity 0, then stop 1. With PARITY=1 the parity bit is 1.
- STOP_BITS=2, send 0x00 -> start plus 8 zeros, then tx=1 for 10 clks before frame_done. Total frame is 11 tick periods.
- tx_valid held high with 0x0F then 0xF0 -> two frames. tx_ready=0 throughout frame 1. Second accept is the cycle after frame_done. Idle high is at least 5 clks between the frames.
- Accept in the same cycle as a baud_tick -> that tick is ignored. The start bit begins on the following tick, 5 clks later.
- Assert rst for one cycle during DATA bit 3 -> next cycle tx=1, tx_ready=1, busy=0, no frame_done. A new byte 0x3C then sends correctly.
